sdram_lowpower_ctrl: RTL and testbench

Parametrised low-power manager for the SDRAM controller: on request it takes the command bus from the arbiter, precharges all banks, and places the device in self-refresh or precharge power-down. On release it exits with the required timing and a programmable burst of auto-refreshes, then hands the bus back. All timing constants and the low-power mode are selectable, and power-down carries a watchdog that forces refresh.

---
 rtl/sdram_pkg.sv | 29 ++
 rtl/sdram_tmr.sv | 38 +++
 rtl/sdram_lowpower_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_sdram_lowpower_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, low-power FSM states, helpers.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REF  = 4'b0001;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_REQ       = 4'd1,
    ST_PRE       = 4'd2,
    ST_WAIT_TRP  = 4'd3,
    ST_SR_ENTRY  = 4'd4,
    ST_SR_HOLD   = 4'd5,
    ST_SR_EXIT   = 4'd6,
    ST_POST_REF  = 4'd7,
    ST_WAIT_TRFC = 4'd8,
    ST_PD_HOLD   = 4'd9,
    ST_PD_EXIT   = 4'd10,
    ST_PD_REF    = 4'd11,
    ST_DONE      = 4'd12
  } lp_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_tmr.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module sdram_tmr #(
  parameter int W = 4
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load has priority, otherwise count down and stick at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_lowpower_ctrl.sv
// Low-power manager: takes the command bus, precharges all banks, enters
// self-refresh or precharge power-down, and exits with the required timing.
module sdram_lowpower_ctrl
  import sdram_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int BA_W         = 2,
  parameter int TRP_CYC      = 2,
  parameter int TRFC_CYC     = 8,
  parameter int TXSR_CYC     = 8,
  parameter int TXP_CYC      = 2,
  parameter int MIN_CKE_CYC  = 4,
  parameter int POST_REF_CNT = 8,
  parameter int PD_MAX_CYC   = 780
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_done,
  input  logic              lp_req,
  input  logic              lp_mode,
  input  logic              bus_gnt,
  output logic              bus_req,
  output logic              lp_ack,
  output logic              lp_done,
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr
);

  localparam int TMR_MAX = max_int(max_int(max_int(TRP_CYC, TRFC_CYC),
                                           max_int(TXSR_CYC, TXP_CYC)),
                                   max_int(MIN_CKE_CYC, PD_MAX_CYC));
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int REF_W   = (POST_REF_CNT > 0) ? $clog2(POST_REF_CNT + 1) : 1;

  // Timer holds "cycles remaining minus one" so the zero flag marks the last cycle
  localparam logic [TMR_W-1:0] LD_TRP  = TMR_W'(TRP_CYC - 1);
  localparam logic [TMR_W-1:0] LD_TRFC = TMR_W'(TRFC_CYC - 1);
  localparam logic [TMR_W-1:0] LD_TXSR = TMR_W'(TXSR_CYC - 1);
  localparam logic [TMR_W-1:0] LD_TXP  = TMR_W'(TXP_CYC - 1);
  localparam logic [TMR_W-1:0] LD_CKE  = TMR_W'(MIN_CKE_CYC - 1);
  localparam logic [TMR_W-1:0] LD_PD   = TMR_W'(PD_MAX_CYC - 1);
  // In power-down the timer counts residency down from PD_MAX; the minimum
  // CKE-low time is met once the count has fallen to this threshold
  localparam logic [TMR_W-1:0] PD_MIN_THR = TMR_W'(PD_MAX_CYC - MIN_CKE_CYC);
  localparam logic [REF_W-1:0] REF_TGT    = REF_W'(POST_REF_CNT);

  lp_state_e          state_q, state_d;
  logic               mode_q, mode_d;
  logic               wd_q, wd_d;
  logic [REF_W-1:0]   ref_q, ref_d;
  logic               cke_q, cke_d;
  logic [3:0]         cmd_q, cmd_d;
  logic               bus_req_q, bus_req_d;
  logic               lp_ack_q, lp_ack_d;
  logic               lp_done_q, lp_done_d;

  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic [TMR_W-1:0]   tmr_cnt;
  logic               tmr_zero;

  sdram_tmr #(.W(TMR_W)) u_tmr (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .cnt_o      (tmr_cnt),
    .zero_o     (tmr_zero)
  );

  // Next state, timer loads on state entry, and next registered outputs
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    wd_d    = wd_q;
    ref_d   = ref_q;

    case (state_q)
      ST_IDLE: begin
        if (lp_req && init_done) begin
          state_d = ST_REQ;
          mode_d  = lp_mode;
          wd_d    = 1'b0;
        end
      end
      ST_REQ: begin
        if (bus_gnt) begin
          state_d = ST_PRE;
        end else if (!lp_req) begin
          state_d = ST_DONE;
        end
      end
      ST_PRE:      state_d = ST_WAIT_TRP;
      ST_WAIT_TRP: begin
        if (tmr_zero) begin
          state_d = mode_q ? ST_PD_HOLD : ST_SR_ENTRY;
        end
      end
      ST_SR_ENTRY: state_d = ST_SR_HOLD;
      ST_SR_HOLD: begin
        if (!lp_req && tmr_zero) begin
          state_d = ST_SR_EXIT;
          ref_d   = '0;
        end
      end
      ST_SR_EXIT: begin
        if (tmr_zero) begin
          state_d = (POST_REF_CNT == 0) ? ST_DONE : ST_POST_REF;
        end
      end
      ST_POST_REF: begin
        state_d = ST_WAIT_TRFC;
        ref_d   = ref_q + REF_W'(1);
      end
      ST_WAIT_TRFC: begin
        if (tmr_zero) begin
          if (wd_q) begin
            // Watchdog refresh done: resume power-down without a new precharge
            wd_d    = 1'b0;
            state_d = lp_req ? ST_PD_HOLD : ST_DONE;
          end else if (ref_q < REF_TGT) begin
            state_d = ST_POST_REF;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_PD_HOLD: begin
        if (!lp_req && (tmr_cnt <= PD_MIN_THR)) begin
          state_d = ST_PD_EXIT;
        end else if (tmr_zero) begin
          state_d = ST_PD_EXIT;
          wd_d    = 1'b1;
        end
      end
      ST_PD_EXIT: begin
        if (tmr_zero) begin
          state_d = wd_q ? ST_PD_REF : ST_DONE;
        end
      end
      ST_PD_REF:   state_d = ST_WAIT_TRFC;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // SR_HOLD deliberately does not reload: it keeps counting the CKE-low
    // minimum that started in SR_ENTRY
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state_d != state_q) begin
      case (state_d)
        ST_WAIT_TRP:  begin tmr_load = 1'b1; tmr_val = LD_TRP;  end
        ST_SR_ENTRY:  begin tmr_load = 1'b1; tmr_val = LD_CKE;  end
        ST_SR_EXIT:   begin tmr_load = 1'b1; tmr_val = LD_TXSR; end
        ST_WAIT_TRFC: begin tmr_load = 1'b1; tmr_val = LD_TRFC; end
        ST_PD_HOLD:   begin tmr_load = 1'b1; tmr_val = LD_PD;   end
        ST_PD_EXIT:   begin tmr_load = 1'b1; tmr_val = LD_TXP;  end
        default:      begin tmr_load = 1'b0; tmr_val = '0;      end
      endcase
    end

    // Outputs decoded from the next state so the registers line up with the state
    cke_d     = !((state_d == ST_SR_ENTRY) || (state_d == ST_SR_HOLD) ||
                  (state_d == ST_PD_HOLD));
    lp_ack_d  = (state_d == ST_SR_HOLD) || (state_d == ST_PD_HOLD);
    bus_req_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    lp_done_d = (state_d == ST_DONE);
    case (state_d)
      ST_PRE:                                cmd_d = CMD_PRECHARGE;
      ST_SR_ENTRY, ST_POST_REF, ST_PD_REF:   cmd_d = CMD_AUTO_REF;
      default:                               cmd_d = CMD_NOP;
    endcase
  end

  // State, context flags and registered SDRAM/bus outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      wd_q      <= 1'b0;
      ref_q     <= '0;
      cke_q     <= 1'b1;
      cmd_q     <= CMD_NOP;
      bus_req_q <= 1'b0;
      lp_ack_q  <= 1'b0;
      lp_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      wd_q      <= wd_d;
      ref_q     <= ref_d;
      cke_q     <= cke_d;
      cmd_q     <= cmd_d;
      bus_req_q <= bus_req_d;
      lp_ack_q  <= lp_ack_d;
      lp_done_q <= lp_done_d;
    end
  end

  assign sdram_cke  = cke_q;
  assign sdram_cmd  = cmd_q;
  assign bus_req    = bus_req_q;
  assign lp_ack     = lp_ack_q;
  assign lp_done    = lp_done_q;
  assign sdram_ba   = '1;
  assign sdram_addr = '1;

endmodule

// File: tb/tb_sdram_lowpower_ctrl.sv
// Directed bench for sdram_lowpower_ctrl: two instances, one with a short
// power-down watchdog and one with no post self-refresh auto-refreshes.
module tb_sdram_lowpower_ctrl;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n, init_done, lp_req, lp_req2, lp_mode, bus_gnt;
  logic        sel2;

  logic        d1_req, d1_ack, d1_done, d1_cke;
  logic [3:0]  d1_cmd;
  logic [1:0]  d1_ba;
  logic [11:0] d1_addr;
  logic        d2_req, d2_ack, d2_done, d2_cke;
  logic [3:0]  d2_cmd;
  logic [1:0]  d2_ba;
  logic [11:0] d2_addr;

  logic        o_req, o_ack, o_done, o_cke;
  logic [3:0]  o_cmd;
  logic [13:0] o_baaddr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  sdram_lowpower_ctrl #(.PD_MAX_CYC(20)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
    .lp_req(lp_req), .lp_mode(lp_mode), .bus_gnt(bus_gnt),
    .bus_req(d1_req), .lp_ack(d1_ack), .lp_done(d1_done),
    .sdram_cke(d1_cke), .sdram_cmd(d1_cmd), .sdram_ba(d1_ba), .sdram_addr(d1_addr)
  );

  sdram_lowpower_ctrl #(.POST_REF_CNT(0)) dut2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
    .lp_req(lp_req2), .lp_mode(lp_mode), .bus_gnt(bus_gnt),
    .bus_req(d2_req), .lp_ack(d2_ack), .lp_done(d2_done),
    .sdram_cke(d2_cke), .sdram_cmd(d2_cmd), .sdram_ba(d2_ba), .sdram_addr(d2_addr)
  );

  assign o_req    = sel2 ? d2_req  : d1_req;
  assign o_ack    = sel2 ? d2_ack  : d1_ack;
  assign o_done   = sel2 ? d2_done : d1_done;
  assign o_cke    = sel2 ? d2_cke  : d1_cke;
  assign o_cmd    = sel2 ? d2_cmd  : d1_cmd;
  assign o_baaddr = sel2 ? {d2_ba, d2_addr} : {d1_ba, d1_addr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic ex(input string tag, input logic cke, input logic [3:0] cmd,
                    input logic ack, input logic breq, input logic done);
    chk({tag, " cke"},     32'(o_cke),    32'(cke));
    chk({tag, " cmd"},     32'(o_cmd),    32'(cmd));
    chk({tag, " lp_ack"},  32'(o_ack),    32'(ack));
    chk({tag, " bus_req"}, 32'(o_req),    32'(breq));
    chk({tag, " lp_done"}, 32'(o_done),   32'(done));
    chk({tag, " ba/addr"}, 32'(o_baaddr), 32'h3fff);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst_n = 1'b1; init_done = 1'b0; lp_req = 1'b0; lp_req2 = 1'b0;
    lp_mode = 1'b0; bus_gnt = 1'b0; sel2 = 1'b0;
    #2 sys_rst_n = 1'b0;
    @(negedge sys_clk); @(negedge sys_clk);
    ex("reset", 1, NOP, 0, 0, 0);
    sys_rst_n = 1'b1; init_done = 1'b1;
    cyc; ex("idle", 1, NOP, 0, 0, 0);

    // Self-refresh with default timing, grant after three request cycles
    lp_mode = 1'b0; lp_req = 1'b1;
    for (int i = 0; i < 3; i++) begin cyc; ex("sr req", 1, NOP, 0, 1, 0); end
    bus_gnt = 1'b1;
    cyc; ex("sr pre", 1, PRE, 0, 1, 0);
    bus_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin cyc; ex("sr trp", 1, NOP, 0, 1, 0); end
    cyc; ex("sr entry", 0, AREF, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin cyc; ex("sr hold", 0, NOP, 1, 1, 0); end
    lp_req = 1'b0;
    for (int i = 0; i < 8; i++) begin cyc; ex("sr txsr", 1, NOP, 0, 1, 0); end
    for (int r = 0; r < 8; r++) begin
      cyc; ex("sr aref", 1, AREF, 0, 1, 0);
      for (int i = 0; i < 8; i++) begin cyc; ex("sr trfc", 1, NOP, 0, 1, 0); end
    end
    cyc; ex("sr done", 1, NOP, 0, 0, 1);
    cyc; ex("sr idle", 1, NOP, 0, 0, 0);

    // Short power-down: request dropped two cycles after ack, min CKE-low is 4
    lp_mode = 1'b1; lp_req = 1'b1;
    cyc; ex("pd req", 1, NOP, 0, 1, 0);
    bus_gnt = 1'b1;
    cyc; ex("pd pre", 1, PRE, 0, 1, 0);
    bus_gnt = 1'b0; lp_mode = 1'b0;   // mode already latched
    for (int i = 0; i < 2; i++) begin cyc; ex("pd trp", 1, NOP, 0, 1, 0); end
    for (int i = 0; i < 2; i++) begin cyc; ex("pd hold", 0, NOP, 1, 1, 0); end
    lp_req = 1'b0;
    for (int i = 0; i < 2; i++) begin cyc; ex("pd min", 0, NOP, 1, 1, 0); end
    for (int i = 0; i < 2; i++) begin cyc; ex("pd txp", 1, NOP, 0, 1, 0); end
    cyc; ex("pd done", 1, NOP, 0, 0, 1);
    cyc; ex("pd idle", 1, NOP, 0, 0, 0);

    // Watchdog: power-down held; forced refresh every 20 cycles, no precharge
    lp_mode = 1'b1; lp_req = 1'b1;
    cyc; ex("wd req", 1, NOP, 0, 1, 0);
    bus_gnt = 1'b1;
    cyc; ex("wd pre", 1, PRE, 0, 1, 0);
    bus_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin cyc; ex("wd trp", 1, NOP, 0, 1, 0); end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 20; i++) begin cyc; ex("wd hold", 0, NOP, 1, 1, 0); end
      for (int i = 0; i < 2; i++) begin cyc; ex("wd txp", 1, NOP, 0, 1, 0); end
      cyc; ex("wd aref", 1, AREF, 0, 1, 0);
      for (int i = 0; i < 8; i++) begin cyc; ex("wd trfc", 1, NOP, 0, 1, 0); end
    end
    cyc; ex("wd rehold", 0, NOP, 1, 1, 0);
    lp_req = 1'b0;
    for (int i = 0; i < 3; i++) begin cyc; ex("wd min", 0, NOP, 1, 1, 0); end
    for (int i = 0; i < 2; i++) begin cyc; ex("wd exit", 1, NOP, 0, 1, 0); end
    cyc; ex("wd done", 1, NOP, 0, 0, 1);
    cyc; ex("wd idle", 1, NOP, 0, 0, 0);

    // Abort while waiting for the grant
    lp_mode = 1'b0; lp_req = 1'b1;
    cyc; ex("abort req", 1, NOP, 0, 1, 0);
    lp_req = 1'b0;
    cyc; ex("abort done", 1, NOP, 0, 0, 1);
    cyc; ex("abort idle", 1, NOP, 0, 0, 0);

    // Reset while in self-refresh hold
    lp_req = 1'b1;
    cyc; ex("rst req", 1, NOP, 0, 1, 0);
    bus_gnt = 1'b1;
    cyc; ex("rst pre", 1, PRE, 0, 1, 0);
    bus_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin cyc; ex("rst trp", 1, NOP, 0, 1, 0); end
    cyc; ex("rst entry", 0, AREF, 0, 1, 0);
    cyc; ex("rst hold", 0, NOP, 1, 1, 0);
    sys_rst_n = 1'b0; init_done = 1'b0;
    #1 ex("rst async", 1, NOP, 0, 0, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin cyc; ex("rst wait init", 1, NOP, 0, 0, 0); end
    init_done = 1'b1;
    cyc; ex("rst init req", 1, NOP, 0, 1, 0);
    lp_req = 1'b0;
    cyc; ex("rst abort done", 1, NOP, 0, 0, 1);
    cyc; ex("rst idle", 1, NOP, 0, 0, 0);

    // No post refreshes; request drops right at SR entry so min CKE-low governs exit
    sel2 = 1'b1; lp_mode = 1'b0; lp_req2 = 1'b1;
    cyc; ex("nr req", 1, NOP, 0, 1, 0);
    bus_gnt = 1'b1;
    cyc; ex("nr pre", 1, PRE, 0, 1, 0);
    bus_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin cyc; ex("nr trp", 1, NOP, 0, 1, 0); end
    cyc; ex("nr entry", 0, AREF, 0, 1, 0);
    lp_req2 = 1'b0;
    for (int i = 0; i < 3; i++) begin cyc; ex("nr hold", 0, NOP, 1, 1, 0); end
    for (int i = 0; i < 8; i++) begin cyc; ex("nr txsr", 1, NOP, 0, 1, 0); end
    cyc; ex("nr done", 1, NOP, 0, 0, 1);
    cyc; ex("nr idle", 1, NOP, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
